// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with modulus, load, wrap/saturate and sticky flags
module updown_counter_param #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] out_next;
    logic             tc_next;
    logic             ovf_evt;
    logic             udf_evt;

    always_comb begin
        out_next = out;
        tc_next  = 1'b0;
        ovf_evt  = 1'b0;
        udf_evt  = 1'b0;
        if (load) begin
            // Clamp keeps out inside 0..MAX_VAL when the modulus is short.
            out_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (s) begin
                if (out >= MAX_VAL) begin
                    out_next = SATURATE ? MAX_VAL : ZERO;
                    tc_next  = 1'b1;
                    ovf_evt  = 1'b1;
                end else begin
                    out_next = out + ONE;
                end
            end else begin
                if (out == ZERO) begin
                    out_next = SATURATE ? ZERO : MAX_VAL;
                    tc_next  = 1'b1;
                    udf_evt  = 1'b1;
                end else begin
                    out_next = out - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= RST_VAL;
            tc  <= 1'b0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            out <= out_next;
            tc  <= tc_next;
            // A new boundary event outranks a simultaneous clear.
            ovf <= ovf_evt | (ovf & ~clr_flags);
            udf <= udf_evt | (udf & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - scoreboard bench for updown_counter_param in three configurations
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst, en, s, load, clr_flags;
    logic [3:0] load_val;

    logic [3:0] out0, out1, out2;
    logic       tc0, tc1, tc2, ovf0, ovf1, ovf2, udf0, udf1, udf2;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       r, e, s, l;
        logic [3:0] lv;
        logic       c;
        logic [1:0] idx;
        logic [3:0] q;
        logic       t, o, u;
    } vec_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [6:0] val;
    } sb_t;

    sb_t sb[$];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b0), .RST_VAL(4'd0)) d0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(out0), .tc(tc0), .ovf(ovf0), .udf(udf0));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RST_VAL(4'd0)) d1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(out1), .tc(tc1), .ovf(ovf1), .udf(udf1));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .RST_VAL(4'd3)) d2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(out2), .tc(tc2), .ovf(ovf2), .udf(udf2));

    function automatic logic [6:0] obs(input logic [1:0] idx);
        case (idx)
            2'd0:    return {out0, tc0, ovf0, udf0};
            2'd1:    return {out1, tc1, ovf1, udf1};
            default: return {out2, tc2, ovf2, udf2};
        endcase
    endfunction

    function automatic vec_t mk(input bit r, input bit e, input bit sd, input bit l, input int lv,
                                input bit c, input int idx, input int q, input bit t, input bit o,
                                input bit u);
        vec_t v;
        v.r = r; v.e = e; v.s = sd; v.l = l; v.lv = 4'(lv); v.c = c;
        v.idx = 2'(idx); v.q = 4'(q); v.t = t; v.o = o; v.u = u;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst = v.r; en = v.e; s = v.s; load = v.l; load_val = v.lv; clr_flags = v.c;
        sb.push_back('{idx: v.idx, val: {v.q, v.t, v.o, v.u}});
    endtask

    task automatic test_reset();
        sb_t x;
        rst = 1'b1; en = 1'b1; s = 1'b1; load = 1'b0; load_val = 4'd0; clr_flags = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sb.push_back('{idx: 2'd0, val: {4'd0, 3'b000}});
        sb.push_back('{idx: 2'd1, val: {4'd0, 3'b000}});
        sb.push_back('{idx: 2'd2, val: {4'd3, 3'b000}});
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            if (obs(x.idx) !== x.val)
                $display("FAIL reset dut%0d: got {out,tc,ovf,udf}=%h want %h", x.idx, obs(x.idx), x.val);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_up();
        sb_t x;
        for (int i = 1; i <= 17; i++) begin
            apply(mk(0, 1, 1, 0, 0, 0, 0, i % 16, i == 16, i >= 16, 0));
            @(posedge clk); #1;
            x = sb.pop_front();
            n_checks++;
            if (obs(x.idx) !== x.val)
                $display("FAIL wrap_up[%0d]: got {out,tc,ovf,udf}=%h want %h", i, obs(x.idx), x.val);
            else n_pass++;
        end
    endtask

    task automatic run_table(input string name, input vec_t v[$]);
        sb_t x;
        foreach (v[i]) begin
            apply(v[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            n_checks++;
            if (obs(x.idx) !== x.val)
                $display("FAIL %s[%0d] dut%0d: got {out,tc,ovf,udf}=%h want %h",
                         name, i, x.idx, obs(x.idx), x.val);
            else n_pass++;
        end
    endtask

    task automatic test_mod_down();
        run_table("mod_down", '{
            mk(1,0,0,0,0,0, 1, 0,0,0,0),
            mk(0,0,0,1,0,0, 1, 0,0,0,0),
            mk(0,1,0,0,0,0, 1, 9,1,0,1),
            mk(0,1,1,0,0,0, 1, 0,1,1,1),
            mk(0,1,0,0,0,0, 1, 9,1,1,1),
            mk(0,1,0,0,0,0, 1, 8,0,1,1),
            mk(0,0,0,0,0,0, 1, 8,0,1,1)});
    endtask

    task automatic test_saturate();
        run_table("saturate", '{
            mk(1,0,0,0,0,0, 2, 3,0,0,0),
            mk(0,0,0,1,8,0, 2, 8,0,0,0),
            mk(0,1,1,0,0,0, 2, 9,0,0,0),
            mk(0,1,1,0,0,0, 2, 9,1,1,0),
            mk(0,1,1,0,0,0, 2, 9,1,1,0),
            mk(0,1,1,0,0,0, 2, 9,1,1,0),
            mk(0,1,0,0,0,0, 2, 8,0,1,0),
            mk(0,0,0,1,1,0, 2, 1,0,1,0),
            mk(0,1,0,0,0,0, 2, 0,0,1,0),
            mk(0,1,0,0,0,0, 2, 0,1,1,1),
            mk(0,1,0,0,0,0, 2, 0,1,1,1),
            mk(0,0,0,0,0,0, 2, 0,0,1,1)});
    endtask

    task automatic test_load_clamp();
        run_table("load_clamp", '{
            mk(1,0,0,0,0,0,  1, 0,0,0,0),
            mk(0,1,1,1,12,0, 1, 9,0,0,0),
            mk(0,0,0,1,5,0,  1, 5,0,0,0),
            mk(0,1,1,1,15,0, 1, 9,0,0,0),
            mk(0,1,1,0,0,0,  1, 0,1,1,0),
            mk(0,1,1,1,3,0,  1, 3,0,1,0),
            mk(0,1,0,1,0,0,  1, 0,0,1,0),
            mk(1,0,0,0,0,0,  0, 0,0,0,0),
            mk(0,1,1,1,12,0, 0, 12,0,0,0),
            mk(0,1,0,1,15,0, 0, 15,0,0,0),
            mk(0,1,1,0,0,0,  0, 0,1,1,0)});
    endtask

    task automatic test_flag_clear();
        run_table("flag_clear", '{
            mk(1,0,0,0,0,0, 1, 0,0,0,0),
            mk(0,0,0,1,9,0, 1, 9,0,0,0),
            mk(0,1,1,0,0,0, 1, 0,1,1,0),
            mk(0,1,1,0,0,0, 1, 1,0,1,0),
            mk(0,1,1,0,0,0, 1, 2,0,1,0),
            mk(0,1,1,0,0,0, 1, 3,0,1,0),
            mk(0,0,0,0,0,1, 1, 3,0,0,0),
            mk(0,0,0,1,9,0, 1, 9,0,0,0),
            mk(0,1,1,0,0,1, 1, 0,1,1,0),
            mk(0,0,0,0,0,0, 1, 0,0,1,0),
            mk(0,1,0,0,0,0, 1, 9,1,1,1),
            mk(0,1,0,0,0,1, 1, 8,0,0,0),
            mk(0,0,0,0,0,0, 1, 8,0,0,0)});
    endtask

    task automatic test_mid_reset();
        vec_t v[$];
        v.push_back(mk(1,0,0,0,0,0,  0, 0,0,0,0));
        v.push_back(mk(0,0,0,1,15,0, 0, 15,0,0,0));
        v.push_back(mk(0,1,1,0,0,0,  0, 0,1,1,0));
        for (int i = 1; i <= 7; i++) v.push_back(mk(0,1,1,0,0,0, 0, i,0,1,0));
        v.push_back(mk(1,1,1,1,5,0,  0, 0,0,0,0));
        v.push_back(mk(0,1,1,0,0,0,  0, 1,0,0,0));
        v.push_back(mk(0,1,1,0,0,0,  2, 5,0,0,0));
        run_table("mid_reset", v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wrap_up();
        test_mod_down();
        test_saturate();
        test_load_clamp();
        test_flag_clear();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
